// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, XZR index and
// the stall/flush control bundle with its canonical values.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MUL_BUSY = 2'd2
    } stall_state_t;

    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_bubble;
        logic memwb_bubble;
    } ctrl_t;

    // Canonical control bundles, one per pipeline situation
    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                   exmem_write: 1'b1, memwb_write: 1'b1, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, exmem_bubble: 1'b0, memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b1, idex_write: 1'b1,
                                     exmem_write: 1'b1, memwb_write: 1'b1, ifid_flush: 1'b1,
                                     idex_bubble: 1'b1, exmem_bubble: 1'b1, memwb_bubble: 1'b1};
    localparam ctrl_t CTRL_MEM_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                          exmem_write: 1'b0, memwb_write: 1'b1, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, exmem_bubble: 1'b0, memwb_bubble: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                      exmem_write: 1'b1, memwb_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, exmem_bubble: 1'b1, memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_MUL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                        exmem_write: 1'b1, memwb_write: 1'b1, ifid_flush: 1'b0,
                                        idex_bubble: 1'b0, exmem_bubble: 1'b1, memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1,
                                        exmem_write: 1'b1, memwb_write: 1'b1, ifid_flush: 1'b0,
                                        idex_bubble: 1'b1, exmem_bubble: 1'b0, memwb_bubble: 1'b0};

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID instruction.
module hazard_lu_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rn1,
    input  logic [4:0] id_rm2,
    input  logic       id_uses_rm2,
    output logic       load_use
);

    // XZR is never a real producer, so it can never create a dependency
    assign load_use = ex_memread && (ex_rd != XZR_IDX) &&
                      ((ex_rd == id_rn1) || (id_uses_rm2 && (ex_rd == id_rm2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, data-memory wait states,
// multi-cycle multiply and taken-branch squash, plus a stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
)
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_RN1_IN,
    input  logic [4:0]       ID_RM2_IN,
    input  logic             ID_USES_RM2_IN,
    input  logic             EX_MEMREAD_IN,
    input  logic [4:0]       EX_RD_IN,
    input  logic             EX_MUL_IN,
    input  logic             MEM_ACCESS_IN,
    input  logic             DMEM_READY_IN,
    input  logic             MEM_BRANCH_TAKEN_IN,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IDEX_WRITE,
    output logic             EXMEM_WRITE,
    output logic             MEMWB_WRITE,
    output logic             IFID_FLUSH,
    output logic             IDEX_BUBBLE,
    output logic             EXMEM_BUBBLE,
    output logic             MEMWB_BUBBLE,
    output logic [1:0]       STALL_STATE,
    output logic [CNT_W-1:0] STALL_CYCLES
);

    localparam int unsigned    MC_W       = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam int unsigned    MUL_LOAD_I = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
    localparam logic [MC_W-1:0] MUL_LOAD  = MC_W'(MUL_LOAD_I);
    localparam logic           MUL_STALLS = (MUL_LATENCY > 1);

    stall_state_t     state;
    logic [MC_W-1:0]  mul_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;
    logic             mem_stall;
    ctrl_t            ctrl;

    hazard_lu_detect u_lu (
        .ex_memread  (EX_MEMREAD_IN),
        .ex_rd       (EX_RD_IN),
        .id_rn1      (ID_RN1_IN),
        .id_rm2      (ID_RM2_IN),
        .id_uses_rm2 (ID_USES_RM2_IN),
        .load_use    (load_use)
    );

    assign mem_stall = MEM_ACCESS_IN && !DMEM_READY_IN;

    // Same-cycle control decode from current state and hazard inputs
    always_comb begin
        ctrl = CTRL_RUN;
        if (RESET) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_stall)                      ctrl = CTRL_MEM_FREEZE;
                    else if (MEM_BRANCH_TAKEN_IN)       ctrl = CTRL_BRANCH;
                    else if (EX_MUL_IN && MUL_STALLS)   ctrl = CTRL_MUL_HOLD;
                    else if (load_use)                  ctrl = CTRL_LOAD_USE;
                end
                ST_MEM_WAIT: begin
                    if (!DMEM_READY_IN) ctrl = CTRL_MEM_FREEZE;
                end
                ST_MUL_BUSY: begin
                    if (mem_stall)              ctrl = CTRL_MEM_FREEZE;
                    else if (mul_cnt != '0)     ctrl = CTRL_MUL_HOLD;
                end
                default: ctrl = CTRL_RUN;
            endcase
        end
    end

    // State, multiply countdown and saturating stall counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_RUN;
            mul_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state <= ST_MEM_WAIT;
                    end else if (!MEM_BRANCH_TAKEN_IN && EX_MUL_IN && MUL_STALLS) begin
                        state   <= ST_MUL_BUSY;
                        mul_cnt <= MUL_LOAD;
                    end
                end
                ST_MEM_WAIT: begin
                    if (DMEM_READY_IN) state <= ST_RUN;
                end
                ST_MUL_BUSY: begin
                    if (!mem_stall) begin
                        if (mul_cnt == '0) state <= ST_RUN;
                        else               mul_cnt <= mul_cnt - MC_W'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign PC_WRITE     = ctrl.pc_write;
    assign IFID_WRITE   = ctrl.ifid_write;
    assign IDEX_WRITE   = ctrl.idex_write;
    assign EXMEM_WRITE  = ctrl.exmem_write;
    assign MEMWB_WRITE  = ctrl.memwb_write;
    assign IFID_FLUSH   = ctrl.ifid_flush;
    assign IDEX_BUBBLE  = ctrl.idex_bubble;
    assign EXMEM_BUBBLE = ctrl.exmem_bubble;
    assign MEMWB_BUBBLE = ctrl.memwb_bubble;
    assign STALL_STATE  = state;
    assign STALL_CYCLES = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a
// behavioural model; a second instance with a 4-bit counter exercises saturation.
module tb_pipeline_hazard_ctrl;

    localparam int L = 4;
    // Bundle bit order: PC, IFID, IDEX, EXMEM, MEMWB writes | IFID flush, IDEX, EXMEM, MEMWB bubbles
    localparam logic [8:0] B_DEFAULT  = 9'b11111_0000;
    localparam logic [8:0] B_RESET    = 9'b01111_1111;
    localparam logic [8:0] B_MEMFRZ   = 9'b00001_0001;
    localparam logic [8:0] B_BRANCH   = 9'b11111_1110;
    localparam logic [8:0] B_MULSTALL = 9'b00011_0010;
    localparam logic [8:0] B_LOADUSE  = 9'b00111_0100;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic [4:0] ID_RN1_IN = '0, ID_RM2_IN = '0, EX_RD_IN = '0;
    logic ID_USES_RM2_IN = 1'b0, EX_MEMREAD_IN = 1'b0, EX_MUL_IN = 1'b0;
    logic MEM_ACCESS_IN = 1'b0, DMEM_READY_IN = 1'b1, MEM_BRANCH_TAKEN_IN = 1'b0;
    logic PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE;
    logic IFID_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE, MEMWB_BUBBLE;
    logic [1:0] STALL_STATE;
    logic [15:0] STALL_CYCLES;
    logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_flush, s_b_idex, s_b_exmem, s_b_memwb;
    logic [1:0] s_state;
    logic [3:0] s_cycles;

    int checks = 0;
    int errors = 0;

    // Model: whether a memory wait is open, and how many EX cycles the multiply still owns
    bit m_mem_wait = 0;
    int m_mul_left = 0;
    int m_cnt16 = 0;
    int m_cnt4 = 0;
    logic [8:0] exp_ctrl;
    logic [1:0] exp_state;
    logic [8:0] obs;

    assign obs = {PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE,
                  IFID_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE, MEMWB_BUBBLE};

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl u_dut (
        .CLK(CLK), .RESET(RESET), .ID_RN1_IN(ID_RN1_IN), .ID_RM2_IN(ID_RM2_IN),
        .ID_USES_RM2_IN(ID_USES_RM2_IN), .EX_MEMREAD_IN(EX_MEMREAD_IN), .EX_RD_IN(EX_RD_IN),
        .EX_MUL_IN(EX_MUL_IN), .MEM_ACCESS_IN(MEM_ACCESS_IN), .DMEM_READY_IN(DMEM_READY_IN),
        .MEM_BRANCH_TAKEN_IN(MEM_BRANCH_TAKEN_IN), .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE),
        .IDEX_WRITE(IDEX_WRITE), .EXMEM_WRITE(EXMEM_WRITE), .MEMWB_WRITE(MEMWB_WRITE),
        .IFID_FLUSH(IFID_FLUSH), .IDEX_BUBBLE(IDEX_BUBBLE), .EXMEM_BUBBLE(EXMEM_BUBBLE),
        .MEMWB_BUBBLE(MEMWB_BUBBLE), .STALL_STATE(STALL_STATE), .STALL_CYCLES(STALL_CYCLES)
    );

    pipeline_hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(4)) u_sat (
        .CLK(CLK), .RESET(RESET), .ID_RN1_IN(ID_RN1_IN), .ID_RM2_IN(ID_RM2_IN),
        .ID_USES_RM2_IN(ID_USES_RM2_IN), .EX_MEMREAD_IN(EX_MEMREAD_IN), .EX_RD_IN(EX_RD_IN),
        .EX_MUL_IN(EX_MUL_IN), .MEM_ACCESS_IN(MEM_ACCESS_IN), .DMEM_READY_IN(DMEM_READY_IN),
        .MEM_BRANCH_TAKEN_IN(MEM_BRANCH_TAKEN_IN), .PC_WRITE(s_pc), .IFID_WRITE(s_ifid),
        .IDEX_WRITE(s_idex), .EXMEM_WRITE(s_exmem), .MEMWB_WRITE(s_memwb),
        .IFID_FLUSH(s_flush), .IDEX_BUBBLE(s_b_idex), .EXMEM_BUBBLE(s_b_exmem),
        .MEMWB_BUBBLE(s_b_memwb), .STALL_STATE(s_state), .STALL_CYCLES(s_cycles)
    );

    // Expected controls for this cycle, straight from the priority rules
    task automatic model_eval();
        bit lu, mstall;
        lu = EX_MEMREAD_IN && (EX_RD_IN != 5'd31) &&
             ((EX_RD_IN == ID_RN1_IN) || (ID_USES_RM2_IN && (EX_RD_IN == ID_RM2_IN)));
        mstall = MEM_ACCESS_IN && !DMEM_READY_IN;
        exp_state = m_mem_wait ? 2'd1 : ((m_mul_left > 0) ? 2'd2 : 2'd0);
        if (RESET)                      exp_ctrl = B_RESET;
        else if (m_mem_wait)            exp_ctrl = DMEM_READY_IN ? B_DEFAULT : B_MEMFRZ;
        else if (m_mul_left > 0)        exp_ctrl = mstall ? B_MEMFRZ :
                                                   ((m_mul_left > 1) ? B_MULSTALL : B_DEFAULT);
        else if (mstall)                exp_ctrl = B_MEMFRZ;
        else if (MEM_BRANCH_TAKEN_IN)   exp_ctrl = B_BRANCH;
        else if (EX_MUL_IN && L > 1)    exp_ctrl = B_MULSTALL;
        else if (lu)                    exp_ctrl = B_LOADUSE;
        else                            exp_ctrl = B_DEFAULT;
    endtask

    task automatic model_advance();
        bit mstall;
        mstall = MEM_ACCESS_IN && !DMEM_READY_IN;
        if (RESET) begin
            m_mem_wait = 0; m_mul_left = 0; m_cnt16 = 0; m_cnt4 = 0;
        end else begin
            if (!exp_ctrl[8]) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (m_mem_wait) begin
                if (DMEM_READY_IN) m_mem_wait = 0;
            end else if (m_mul_left > 0) begin
                if (!mstall) m_mul_left--;
            end else if (mstall) begin
                m_mem_wait = 1;
            end else if (!MEM_BRANCH_TAKEN_IN && EX_MUL_IN && L > 1) begin
                m_mul_left = L - 1;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic memread, input logic [4:0] rd,
                         input logic [4:0] rn1, input logic [4:0] rm2, input logic uses,
                         input logic mul, input logic acc, input logic rdy, input logic br);
        RESET = rst; EX_MEMREAD_IN = memread; EX_RD_IN = rd; ID_RN1_IN = rn1;
        ID_RM2_IN = rm2; ID_USES_RM2_IN = uses; EX_MUL_IN = mul;
        MEM_ACCESS_IN = acc; DMEM_READY_IN = rdy; MEM_BRANCH_TAKEN_IN = br;
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 1, 5, 5, 0, 0, 1, 1, 0, 1);
        checks++;
        if (obs !== B_RESET) begin
            errors++; $display("FAIL reset_ctrl: got %b want %b", obs, B_RESET);
        end
        checks++;
        if (STALL_STATE !== 2'd0 || STALL_CYCLES !== 16'd0 || s_cycles !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs: state %0d cnt %0d satcnt %0d want 0 0 0",
                     STALL_STATE, STALL_CYCLES, s_cycles);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== B_DEFAULT) begin
            errors++; $display("FAIL idle_ctrl: got %b want %b", obs, B_DEFAULT);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [4:0] rd, rn1, rm2;
        logic uses, memread;
        logic [8:0] want;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin memread = 1; rd = 5;  rn1 = 5;  rm2 = 0;  uses = 0; want = B_LOADUSE; end
                1: begin memread = 1; rd = 31; rn1 = 31; rm2 = 31; uses = 1; want = B_DEFAULT; end
                2: begin memread = 1; rd = 7;  rn1 = 1;  rm2 = 7;  uses = 0; want = B_DEFAULT; end
                3: begin memread = 1; rd = 7;  rn1 = 1;  rm2 = 7;  uses = 1; want = B_LOADUSE; end
                4: begin memread = 0; rd = 9;  rn1 = 9;  rm2 = 9;  uses = 1; want = B_DEFAULT; end
                default: begin memread = 1; rd = 3; rn1 = 4; rm2 = 2; uses = 1; want = B_DEFAULT; end
            endcase
            drive(0, memread, rd, rn1, rm2, uses, 0, 0, 1, 0);
            checks++;
            if (obs !== want || STALL_STATE !== 2'd0) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b state %0d want %b state 0",
                         i, obs, STALL_STATE, want);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            checks++;
            if (obs !== B_MEMFRZ || STALL_STATE !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b state %0d want %b", i, obs, STALL_STATE, B_MEMFRZ);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (obs !== B_DEFAULT || STALL_STATE !== 2'd1 || STALL_CYCLES !== 16'd3) begin
            errors++;
            $display("FAIL mem_ready: got %b state %0d cnt %0d want %b state 1 cnt 3",
                     obs, STALL_STATE, STALL_CYCLES, B_DEFAULT);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (STALL_STATE !== 2'd0 || STALL_CYCLES !== 16'd3) begin
            errors++;
            $display("FAIL mem_exit: state %0d cnt %0d want 0 3", STALL_STATE, STALL_CYCLES);
        end
        tick();
    endtask

    task automatic test_multiply();
        int pc_low = 0;
        for (int i = 0; i < L; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            if (!PC_WRITE) pc_low++;
            checks++;
            if (obs !== ((i < L - 1) ? B_MULSTALL : B_DEFAULT) ||
                STALL_STATE !== ((i == 0) ? 2'd0 : 2'd2)) begin
                errors++;
                $display("FAIL mul[%0d]: got %b state %0d", i, obs, STALL_STATE);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (pc_low != L - 1 || STALL_STATE !== 2'd0 || obs !== B_DEFAULT) begin
            errors++;
            $display("FAIL mul_done: stalls %0d state %0d want %0d 0", pc_low, STALL_STATE, L - 1);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        drive(0, 1, 5, 5, 0, 0, 0, 0, 1, 1);
        checks++;
        if (obs !== B_BRANCH) begin
            errors++; $display("FAIL branch_vs_lu: got %b want %b", obs, B_BRANCH);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        checks++;
        if (obs !== B_BRANCH) begin
            errors++; $display("FAIL branch_vs_mul: got %b want %b", obs, B_BRANCH);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        checks++;
        if (STALL_STATE !== 2'd0 || obs !== B_MEMFRZ) begin
            errors++;
            $display("FAIL mem_vs_branch: got %b state %0d want %b state 0", obs, STALL_STATE, B_MEMFRZ);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
    endtask

    task automatic test_reset_mid_mul();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        checks++;
        if (STALL_STATE !== 2'd2 || obs !== B_RESET) begin
            errors++;
            $display("FAIL rst_in_mul: got %b state %0d want %b state 2", obs, STALL_STATE, B_RESET);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (STALL_STATE !== 2'd0 || STALL_CYCLES !== 16'd0 || obs !== B_DEFAULT) begin
            errors++;
            $display("FAIL rst_mul_after: got %b state %0d cnt %0d want %b 0 0",
                     obs, STALL_STATE, STALL_CYCLES, B_DEFAULT);
        end
        tick();
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (s_cycles !== 4'd15 || STALL_CYCLES !== 16'd20) begin
            errors++;
            $display("FAIL saturate: satcnt %0d cnt %0d want 15 20", s_cycles, STALL_CYCLES);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) == 0));
            checks++;
            if (obs !== exp_ctrl || STALL_STATE !== exp_state || s_state !== exp_state) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got %b state %0d/%0d want %b state %0d",
                         n, obs, STALL_STATE, s_state, exp_ctrl, exp_state);
            end
            checks++;
            if (STALL_CYCLES !== 16'(m_cnt16) || s_cycles !== 4'(m_cnt4)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d",
                         n, STALL_CYCLES, s_cycles, m_cnt16, m_cnt4);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_multiply();
        test_branch_priority();
        test_reset_mid_mul();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
